// File: rtl/nios2_mem_pkg.sv
// Shared types and constants for the Nios II on-chip RAM arbiter slice.
package nios2_mem_pkg;

    localparam int MEM_ADDR_W = 10;
    localparam int MEM_DATA_W = 32;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_id_e;

    // One entry of the read-return pipeline: which master a RAM q word belongs to.
    typedef struct packed {
        logic       valid;
        master_id_e id;
    } rd_tag_t;

endpackage

// File: rtl/nios2_rr_arb2.sv
// Two-way round-robin arbiter; under contention the current owner keeps the
// grant for at most MAX_HOLD consecutive cycles before the other master wins.
module nios2_rr_arb2
    import nios2_mem_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       onehot
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    master_id_e        last_grant;
    logic              owner_valid;
    logic [HOLD_W-1:0] hold_cnt;
    master_id_e        pick;

    always_comb begin
        pick  = M0;
        grant = 2'b00;
        if (req == 2'b01) begin
            pick = M0;
        end else if (req == 2'b10) begin
            pick = M1;
        end else if (owner_valid && (hold_cnt < HOLD_LAST)) begin
            pick = last_grant;
        end else begin
            pick = (last_grant == M0) ? M1 : M0;
        end
        if (req != 2'b00) begin
            grant = (pick == M1) ? 2'b10 : 2'b01;
        end
        onehot = grant[0] | grant[1];
    end

    // An idle cycle ends ownership, so the next grant starts a fresh streak.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_grant  <= M1;
            owner_valid <= 1'b0;
            hold_cnt    <= '0;
        end else if (onehot) begin
            if (owner_valid && (pick == last_grant)) begin
                if (hold_cnt != '1) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end else begin
                hold_cnt <= '0;
            end
            last_grant  <= pick;
            owner_valid <= 1'b1;
        end else begin
            owner_valid <= 1'b0;
            hold_cnt    <= '0;
        end
    end

endmodule

// File: rtl/nios2_onchip_ram_arbiter.sv
// Shares the single-port on-chip RAM between the Nios II data master (M0) and a
// DMA/peripheral master (M1), routing pipelined read data back to the issuer.
module nios2_onchip_ram_arbiter
    import nios2_mem_pkg::*;
#(
    parameter int ADDR_W       = MEM_ADDR_W,
    parameter int DATA_W       = MEM_DATA_W,
    parameter int READ_LATENCY = 1,
    parameter int MAX_HOLD     = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata
);

    // Handshake: a master's request (read|write) is accepted in a cycle where it
    // is high and waitrequest is low; address/data/byteenable must hold until then.
    logic [1:0] raw_req;
    logic [1:0] arb_req;
    logic [1:0] grant;
    logic       issue;
    logic       sel_m1;
    logic       sel_write;
    rd_tag_t    tag_in;
    rd_tag_t    tag_q [READ_LATENCY];
    rd_tag_t    tag_out;

    assign raw_req = {m1_read | m1_write, m0_read | m0_write};
    assign arb_req = raw_req & {2{reset_n}};

    nios2_rr_arb2 #(
        .MAX_HOLD (MAX_HOLD)
    ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (arb_req),
        .grant   (grant),
        .onehot  (issue)
    );

    assign sel_m1         = grant[1];
    assign m0_waitrequest = raw_req[0] & ~grant[0];
    assign m1_waitrequest = raw_req[1] & ~grant[1];

    // read&write together resolves to a write.
    assign sel_write      = sel_m1 ? m1_write : m0_write;
    assign ram_address    = sel_m1 ? m1_address : m0_address;
    assign ram_byteenable = sel_m1 ? m1_byteenable : m0_byteenable;
    assign ram_writedata  = sel_m1 ? m1_writedata : m0_writedata;
    assign ram_chipselect = issue;
    assign ram_write      = issue & sel_write;
    assign ram_clken      = reset_n;

    always_comb begin
        tag_in.valid = issue & ~sel_write;
        tag_in.id    = sel_m1 ? M1 : M0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_q[i] <= '{valid: 1'b0, id: M0};
            end
        end else begin
            tag_q[0] <= tag_in;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Masking with reset_n drops a read whose data would land in a reset cycle.
    assign tag_out          = tag_q[READ_LATENCY-1];
    assign m0_readdatavalid = reset_n & tag_out.valid & (tag_out.id == M0);
    assign m1_readdatavalid = reset_n & tag_out.valid & (tag_out.id == M1);
    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;

endmodule

// File: tb/tb_nios2_onchip_ram_arbiter.sv
// Bench for nios2_onchip_ram_arbiter paired with a 1024x32 RAM model; a
// reference model predicts grants and read data, a monitor checks returns.
module tb_nios2_onchip_ram_arbiter;

    localparam int AW       = 10;
    localparam int DW       = 32;
    localparam int MAX_HOLD = 4;

    // ---------------- clock / reset ----------------
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] m0_address, m1_address;
    logic [3:0]    m0_byteenable, m1_byteenable;
    logic          m0_read, m0_write, m1_read, m1_write;
    logic [DW-1:0] m0_writedata, m1_writedata;
    logic          m0_waitrequest, m1_waitrequest;
    logic [DW-1:0] m0_readdata, m1_readdata;
    logic          m0_readdatavalid, m1_readdatavalid;
    logic [AW-1:0] ram_address;
    logic [3:0]    ram_byteenable;
    logic          ram_chipselect, ram_write, ram_clken;
    logic [DW-1:0] ram_writedata, ram_readdata;

    nios2_onchip_ram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1), .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable),
        .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable),
        .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_chipselect(ram_chipselect), .ram_write(ram_write),
        .ram_writedata(ram_writedata), .ram_clken(ram_clken),
        .ram_readdata(ram_readdata)
    );

    // ---------------- 1024x32 RAM model (registered address, unregistered q) ----------------
    logic [DW-1:0] ram_mem [1024] = '{default: '0};
    logic [AW-1:0] ram_addr_q = '0;
    always @(posedge clk) begin
        if (ram_clken) begin
            if (ram_chipselect && ram_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
                end
            end
            ram_addr_q <= ram_address;
        end
    end
    assign ram_readdata = ram_mem[ram_addr_q];

    // ---------------- reference model state ----------------
    logic [DW-1:0] ref_mem [1024] = '{default: '0};
    int            mdl_winner = 1;
    int            mdl_streak = 0;
    bit            mdl_busy   = 1'b0;
    int            grant_log[$];
    logic [64:0]   exp_q[$];          // {due_cycle[31:0], id, data[31:0]}
    logic [DW-1:0] last_rd_data = '0;
    int            last_rd_id = -1;

    int checks = 0;
    int errors = 0;

    // Pending request per master, held until the DUT accepts it.
    logic          rq_act  [2] = '{1'b0, 1'b0};
    logic          rq_wr   [2];
    logic [AW-1:0] rq_addr [2];
    logic [3:0]    rq_be   [2];
    logic [DW-1:0] rq_wd   [2];
    int            rq_wait [2] = '{0, 0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_pins();
        m0_read       = rq_act[0] && !rq_wr[0];
        m0_write      = rq_act[0] && rq_wr[0];
        m0_address    = rq_addr[0];
        m0_byteenable = rq_be[0];
        m0_writedata  = rq_wd[0];
        m1_read       = rq_act[1] && !rq_wr[1];
        m1_write      = rq_act[1] && rq_wr[1];
        m1_address    = rq_addr[1];
        m1_byteenable = rq_be[1];
        m1_writedata  = rq_wd[1];
    endtask

    task automatic issue(input int m, input bit wr, input logic [AW-1:0] a,
                         input logic [3:0] be, input logic [DW-1:0] wd);
        rq_act[m]  = 1'b1;
        rq_wr[m]   = wr;
        rq_addr[m] = a;
        rq_be[m]   = be;
        rq_wd[m]   = wd;
        rq_wait[m] = 0;
    endtask

    // Compare this cycle's DUT outputs to the model, then advance the model.
    task automatic check_cycle();
        int g;
        bit r0, r1, acc;
        r0 = rq_act[0];
        r1 = rq_act[1];
        g  = -1;
        if (reset_n) begin
            if (r0 && !r1) g = 0;
            else if (r1 && !r0) g = 1;
            else if (r0 && r1) g = (mdl_busy && mdl_streak < MAX_HOLD) ? mdl_winner : 1 - mdl_winner;
        end
        chk("m0_waitrequest", 64'(m0_waitrequest), 64'(r0 && g != 0));
        chk("m1_waitrequest", 64'(m1_waitrequest), 64'(r1 && g != 1));
        chk("ram_chipselect", 64'(ram_chipselect), 64'(g >= 0));
        chk("ram_clken", 64'(ram_clken), 64'(reset_n));
        if (!reset_n) begin
            chk("m0_readdatavalid_in_reset", 64'(m0_readdatavalid), 64'(0));
            chk("m1_readdatavalid_in_reset", 64'(m1_readdatavalid), 64'(0));
        end
        if (g >= 0 && ram_chipselect) begin
            chk("ram_address", 64'(ram_address), 64'(rq_addr[g]));
            chk("ram_write", 64'(ram_write), 64'(rq_wr[g]));
            if (rq_wr[g]) begin
                chk("ram_byteenable", 64'(ram_byteenable), 64'(rq_be[g]));
                chk("ram_writedata", 64'(ram_writedata), 64'(rq_wd[g]));
            end
        end
        if (!reset_n) begin
            mdl_winner = 1;
            mdl_streak = 0;
            mdl_busy   = 1'b0;
        end else if (g >= 0) begin
            mdl_streak = (mdl_busy && g == mdl_winner) ? mdl_streak + 1 : 1;
            mdl_winner = g;
            mdl_busy   = 1'b1;
        end else begin
            mdl_busy   = 1'b0;
            mdl_streak = 0;
        end
        for (int m = 0; m < 2; m++) begin
            if (rq_act[m]) begin
                acc = (m == 0) ? !m0_waitrequest : !m1_waitrequest;
                if (acc) begin
                    grant_log.push_back(m);
                    if (rq_wr[m]) begin
                        for (int b = 0; b < 4; b++) begin
                            if (rq_be[m][b]) ref_mem[rq_addr[m]][8*b +: 8] = rq_wd[m][8*b +: 8];
                        end
                    end else begin
                        exp_q.push_back({32'(cyc + 1), 1'(m), ref_mem[rq_addr[m]]});
                    end
                    rq_act[m]  = 1'b0;
                    rq_wait[m] = 0;
                end else begin
                    rq_wait[m]++;
                    if (rq_wait[m] > 64) begin
                        checks++;
                        errors++;
                        $display("FAIL accept_timeout m%0d waited=%0d limit=64", m, rq_wait[m]);
                        rq_act[m] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        drive_pins();
        step();
    endtask

    task automatic wait_done(input int max_cycles);
        int k = 0;
        while ((rq_act[0] || rq_act[1]) && k < max_cycles) begin
            cycle();
            k++;
        end
        cycle();
    endtask

    task automatic apply_reset(input int n, input bit hold_m0_read);
        reset_n   = 1'b0;
        exp_q.delete();
        rq_act[0] = 1'b0;
        rq_act[1] = 1'b0;
        if (hold_m0_read) issue(0, 1'b0, 10'h005, 4'hF, 32'h0);
        repeat (n) cycle();
        reset_n = 1'b1;
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [64:0] e;
        logic        v;
        forever begin
            @(negedge clk);
            assert (!(m0_read && m0_write)) else $error("m0 drove read and write together");
            assert (!(m1_read && m1_write)) else $error("m1 drove read and write together");
            while (exp_q.size() > 0 && int'(exp_q[0][64:33]) < cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL readdatavalid_missing id=%0d due=%0d now=%0d", e[32], e[64:33], cyc);
            end
            for (int m = 0; m < 2; m++) begin
                v = (m == 0) ? m0_readdatavalid : m1_readdatavalid;
                if (v) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL readdatavalid_unexpected m%0d actual=1 expected=0", m);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rd_id", 64'(m), 64'(e[32]));
                        chk("rd_cycle", 64'(cyc), 64'(e[64:33]));
                        chk("rd_data", 64'((m == 0) ? m0_readdata : m1_readdata), 64'(e[31:0]));
                        last_rd_data = (m == 0) ? m0_readdata : m1_readdata;
                        last_rd_id   = m;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        drive_pins();

        // Reset held three cycles with a pending M0 read; accepted right after release.
        apply_reset(3, 1'b1);
        cycle();
        chk("reset_first_accept_pending", 64'(rq_act[0]), 64'(0));
        wait_done(10);

        // Solo write then read by M0.
        issue(0, 1'b1, 10'h005, 4'b1111, 32'hDEADBEEF);
        wait_done(10);
        issue(0, 1'b0, 10'h005, 4'b1111, 32'h0);
        wait_done(10);
        chk("solo_read_data", 64'(last_rd_data), 64'(32'hDEADBEEF));
        chk("solo_read_id", 64'(last_rd_id), 64'(0));

        // Byte-lane write at the top address by M1.
        issue(1, 1'b1, 10'h3FF, 4'b0101, 32'h11223344);
        wait_done(10);
        issue(1, 1'b0, 10'h3FF, 4'b1111, 32'h0);
        wait_done(10);
        chk("byte_lane_data", 64'(last_rd_data), 64'(32'h00220044));
        chk("byte_lane_id", 64'(last_rd_id), 64'(1));

        // Contention: both masters stream reads.
        grant_log.delete();
        for (int k = 0; k < 40 && grant_log.size() < 12; k++) begin
            for (int m = 0; m < 2; m++) begin
                if (!rq_act[m]) issue(m, 1'b0, 10'($urandom_range(0, 1023)), 4'hF, 32'h0);
            end
            cycle();
        end
        rq_act[0] = 1'b0;
        rq_act[1] = 1'b0;
        cycle();
        cycle();
        chk("contention_grant_count", 64'(grant_log.size() >= 12), 64'(1));
        for (int i = 0; i < 12 && i < grant_log.size(); i++) begin
            chk("contention_grant_order", 64'(grant_log[i]), 64'((i / 4) % 2));
        end

        // Alternation between M0 at 0x010 and M1 at 0x020.
        issue(0, 1'b1, 10'h010, 4'hF, $urandom);
        issue(1, 1'b1, 10'h020, 4'hF, $urandom);
        wait_done(10);
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) issue(0, 1'b0, 10'h010, 4'hF, 32'h0);
            else            issue(1, 1'b0, 10'h020, 4'hF, 32'h0);
            cycle();
        end
        wait_done(10);

        // Reset the cycle after an M1 read is accepted; its data must never return.
        issue(1, 1'b0, 10'h020, 4'hF, 32'h0);
        cycle();
        apply_reset(2, 1'b0);
        repeat (3) cycle();

        // Randomized mixed traffic over a small address window plus the top word.
        for (int k = 0; k < 300; k++) begin
            for (int m = 0; m < 2; m++) begin
                if (!rq_act[m] && $urandom_range(0, 99) < 60) begin
                    issue(m, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 9) == 0) ? 10'h3FF : 10'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)), $urandom);
                end
            end
            cycle();
        end
        wait_done(100);
        repeat (3) cycle();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
